// File: rtl/regfile_multiport.sv
// -----------------------------------------------------------------------------
// regfile_multiport
//
// Parametrised integer register file for the core datapath: one write port
// (from writeback) and NRD independent combinational read ports (from decode).
// After reset a sequential sweep clears every register, one per cycle, while
// busy is held high; the core must stall until busy drops.
//
// Parameters:
//   XLEN     - register width in bits
//   NREGS    - number of architectural registers (2..64, any value)
//   AW       - address width, 2**AW >= NREGS
//   NRD      - number of read ports (1..4)
//   BYPASS   - 1: a legal same-cycle write is forwarded to matching read ports
//   ZERO_REG - 1: register 0 reads as zero and ignores writes
//
// Ports:
//   clk      - rising-edge clock
//   rst      - synchronous active-high reset (restarts the clear sweep)
//   RegWrite - write enable
//   A3       - write address
//   write    - write data
//   raddr    - packed read addresses, port k at [k*AW +: AW]
//   rdata    - packed read data, port k at [k*XLEN +: XLEN]
//   busy     - high while the clear sweep is running
// -----------------------------------------------------------------------------
module regfile_multiport #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int AW       = 5,
    parameter int NRD      = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 RegWrite,
    input  logic [AW-1:0]        A3,
    input  logic [XLEN-1:0]      write,
    input  logic [NRD*AW-1:0]    raddr,
    output logic [NRD*XLEN-1:0]  rdata,
    output logic                 busy
);

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    // Power-up state matches the post-reset state so the sweep also runs
    // after configuration without an explicit reset pulse.
    state_t          state_q = CLEAR;
    logic [AW-1:0]   cnt_q   = '0;
    logic            busy_q  = 1'b1;

    logic [XLEN-1:0] regs_q [NREGS];

    logic            wr_legal;
    logic            ram_we;
    logic [AW-1:0]   ram_waddr;
    logic [XLEN-1:0] ram_wdata;

    // ------------------------------------------------------------------
    // Clear-sweep FSM. busy is registered alongside the state so it is
    // glitch-free for the stall logic in the core.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
        end else begin
            case (state_q)
                CLEAR: begin
                    if (int'(cnt_q) == NREGS - 1) begin
                        state_q <= READY;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q   <= cnt_q + AW'(1);
                    end
                end
                default: begin
                    state_q <= READY;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;

    // A write takes effect only in READY, in range, and not to a hardwired x0.
    // The same qualifier gates the bypass so illegal writes are never forwarded.
    assign wr_legal = (state_q == READY) && RegWrite && (int'(A3) < NREGS) &&
                      !((ZERO_REG != 0) && (A3 == '0));

    // Single shared write port: the sweep and the architectural write never
    // overlap because architectural writes are blocked while clearing.
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = A3;
        ram_wdata = write;
        if (state_q == CLEAR) begin
            ram_we    = 1'b1;
            ram_waddr = cnt_q;
            ram_wdata = '0;
        end else if (wr_legal) begin
            ram_we    = 1'b1;
        end
    end

    // Storage carries no reset: contents are zeroed by the sweep instead.
    always_ff @(posedge clk) begin
        if (!rst && ram_we) begin
            regs_q[ram_waddr] <= ram_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Combinational read ports
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
            logic [AW-1:0]   ra;
            logic [XLEN-1:0] rd;

            assign ra = raddr[gi*AW +: AW];

            always_comb begin
                rd = '0;
                if (busy_q) begin
                    rd = '0;
                end else if (int'(ra) >= NREGS) begin
                    rd = '0;
                end else if ((ZERO_REG != 0) && (ra == '0)) begin
                    rd = '0;
                end else if ((BYPASS != 0) && wr_legal && (A3 == ra)) begin
                    rd = write;
                end else begin
                    rd = regs_q[ra];
                end
            end

            assign rdata[gi*XLEN +: XLEN] = rd;
        end
    endgenerate

endmodule

// File: tb/tb_regfile_multiport.sv
module tb_regfile_multiport;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Three instances: default config, no-bypass, and non-power-of-two depth.
    logic        rst_s [3];
    logic        we_s  [3];
    logic [4:0]  a3_s  [3];
    logic [31:0] wd_s  [3];
    logic [4:0]  ra_s  [3][3];

    logic [63:0] rd0, rd1;
    logic [95:0] rd2;
    logic        busy0, busy1, busy2;

    regfile_multiport #(.XLEN(32), .NREGS(32), .AW(5), .NRD(2), .BYPASS(1), .ZERO_REG(1)) u_dut0 (
        .clk(clk), .rst(rst_s[0]), .RegWrite(we_s[0]), .A3(a3_s[0]), .write(wd_s[0]),
        .raddr({ra_s[0][1], ra_s[0][0]}), .rdata(rd0), .busy(busy0)
    );

    regfile_multiport #(.XLEN(32), .NREGS(32), .AW(5), .NRD(2), .BYPASS(0), .ZERO_REG(1)) u_dut1 (
        .clk(clk), .rst(rst_s[1]), .RegWrite(we_s[1]), .A3(a3_s[1]), .write(wd_s[1]),
        .raddr({ra_s[1][1], ra_s[1][0]}), .rdata(rd1), .busy(busy1)
    );

    regfile_multiport #(.XLEN(32), .NREGS(24), .AW(5), .NRD(3), .BYPASS(1), .ZERO_REG(1)) u_dut2 (
        .clk(clk), .rst(rst_s[2]), .RegWrite(we_s[2]), .A3(a3_s[2]), .write(wd_s[2]),
        .raddr({ra_s[2][2], ra_s[2][1], ra_s[2][0]}), .rdata(rd2), .busy(busy2)
    );

    // Scoreboard: port -1 means the busy flag.
    typedef struct {
        int          dut;
        int          port;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    int   tests_run = 0;
    int   tests_failed = 0;

    function automatic logic [31:0] actual(int d, int p);
        logic [31:0] v;
        v = '0;
        case (d)
            0: v = (p < 0) ? {31'd0, busy0} : rd0[p*32 +: 32];
            1: v = (p < 0) ? {31'd0, busy1} : rd1[p*32 +: 32];
            default: v = (p < 0) ? {31'd0, busy2} : rd2[p*32 +: 32];
        endcase
        return v;
    endfunction

    // Monitor: outputs are sampled on the falling edge, away from the
    // active edge; every expectation queued during this cycle is checked.
    exp_t        mon_e;
    logic [31:0] mon_act;
    always @(negedge clk) begin
        while (sb_q.size() > 0) begin
            mon_e   = sb_q.pop_front();
            mon_act = actual(mon_e.dut, mon_e.port);
            tests_run++;
            if (mon_act !== mon_e.exp) begin
                tests_failed++;
                $display("[TB] FAIL %s: dut%0d port%0d got %h required %h",
                         mon_e.name, mon_e.dut, mon_e.port, mon_act, mon_e.exp);
            end else begin
                $display("[TB] ok   %s: dut%0d port%0d = %h",
                         mon_e.name, mon_e.dut, mon_e.port, mon_act);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_v(int d, int p, logic [31:0] v, string n);
        exp_t e;
        e.dut  = d;
        e.port = p;
        e.exp  = v;
        e.name = n;
        sb_q.push_back(e);
    endtask

    task automatic set_wr(int d, logic we, logic [4:0] a, logic [31:0] v);
        we_s[d] = we;
        a3_s[d] = a;
        wd_s[d] = v;
    endtask

    task automatic set_rd(int d, logic [4:0] r0, logic [4:0] r1, logic [4:0] r2);
        ra_s[d][0] = r0;
        ra_s[d][1] = r1;
        ra_s[d][2] = r2;
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            rst_s[d] = 1'b1;
            set_wr(d, 1'b0, 5'd0, 32'h0);
            set_rd(d, 5'd0, 5'd0, 5'd0);
        end

        // ---------------- dut0: clear sweep after a 2-cycle reset --------
        tick();
        tick();
        rst_s[0] = 1'b0;
        set_rd(0, 5'd3, 5'd3, 5'd0);
        for (int i = 0; i <= 32; i++) begin
            if (i == 10) set_wr(0, 1'b1, 5'd3, 32'hFFFF_0000);   // blocked by busy
            else if (i == 32) set_wr(0, 1'b1, 5'd9, 32'h1111_2222); // first READY cycle
            else set_wr(0, 1'b0, 5'd0, 32'h0);
            if (i == 32) set_rd(0, 5'd0, 5'd1, 5'd0);
            if (i == 0 || i == 10 || i >= 31) begin
                expect_v(0, -1, (i < 32) ? 32'd1 : 32'd0, "sweep_busy");
                expect_v(0, 0, 32'h0, "sweep_rd0");
                expect_v(0, 1, 32'h0, "sweep_rd1");
            end
            tick();
        end
        set_wr(0, 1'b0, 5'd0, 32'h0);
        for (int r = 0; r < 32; r++) begin
            set_rd(0, 5'(r), 5'(31 - r), 5'd0);
            expect_v(0, 0, (r == 9) ? 32'h1111_2222 : 32'h0, "cleared_p0");
            expect_v(0, 1, (31 - r == 9) ? 32'h1111_2222 : 32'h0, "cleared_p1");
            tick();
        end

        // ---------------- dut0: x0 hardwired, x5 ordinary ----------------
        set_wr(0, 1'b1, 5'd5, 32'hDEAD_BEEF);
        set_rd(0, 5'd5, 5'd0, 5'd0);
        expect_v(0, 0, 32'hDEAD_BEEF, "wr_x5_bypass");
        expect_v(0, 1, 32'h0, "x0_read");
        tick();
        set_wr(0, 1'b1, 5'd0, 32'h1234_5678);
        set_rd(0, 5'd0, 5'd0, 5'd0);
        expect_v(0, 0, 32'h0, "x0_no_bypass_p0");
        expect_v(0, 1, 32'h0, "x0_no_bypass_p1");
        tick();
        set_wr(0, 1'b0, 5'd0, 32'h0);
        set_rd(0, 5'd5, 5'd0, 5'd0);
        expect_v(0, 0, 32'hDEAD_BEEF, "x5_readback");
        expect_v(0, 1, 32'h0, "x0_after_write");
        tick();

        // ---------------- dut0: bypass to both ports ---------------------
        set_wr(0, 1'b1, 5'd7, 32'h0000_0001);
        tick();
        set_wr(0, 1'b1, 5'd7, 32'hA5A5_A5A5);
        set_rd(0, 5'd7, 5'd7, 5'd0);
        expect_v(0, 0, 32'hA5A5_A5A5, "bypass_p0");
        expect_v(0, 1, 32'hA5A5_A5A5, "bypass_p1");
        tick();
        set_wr(0, 1'b0, 5'd0, 32'h0);
        expect_v(0, 0, 32'hA5A5_A5A5, "x7_stored_p0");
        expect_v(0, 1, 32'hA5A5_A5A5, "x7_stored_p1");
        tick();

        // ---------------- dut0: reset asserted mid-sweep -----------------
        rst_s[0] = 1'b1;
        tick();
        rst_s[0] = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        rst_s[0] = 1'b1;                      // sweep cycle 20
        expect_v(0, -1, 32'd1, "midsweep_busy_at_rst");
        tick();
        rst_s[0] = 1'b0;
        for (int i = 0; i <= 32; i++) begin
            if (i == 0 || i == 31 || i == 32)
                expect_v(0, -1, (i < 32) ? 32'd1 : 32'd0, "restart_busy");
            if (i < 32) tick();
        end
        for (int r = 0; r < 32; r++) begin
            set_rd(0, 5'(r), 5'(r), 5'd0);
            expect_v(0, 0, 32'h0, "recleared_p0");
            expect_v(0, 1, 32'h0, "recleared_p1");
            tick();
        end

        // ---------------- dut1: BYPASS = 0 -------------------------------
        rst_s[1] = 1'b0;
        for (int i = 0; i <= 32; i++) begin
            if (i == 31 || i == 32)
                expect_v(1, -1, (i < 32) ? 32'd1 : 32'd0, "nb_sweep_busy");
            if (i < 32) tick();
        end
        set_wr(1, 1'b1, 5'd7, 32'h0000_0001);
        tick();
        set_wr(1, 1'b1, 5'd7, 32'hA5A5_A5A5);
        set_rd(1, 5'd7, 5'd7, 5'd0);
        expect_v(1, 0, 32'h0000_0001, "nobypass_old_p0");
        expect_v(1, 1, 32'h0000_0001, "nobypass_old_p1");
        tick();
        set_wr(1, 1'b0, 5'd0, 32'h0);
        expect_v(1, 0, 32'hA5A5_A5A5, "nobypass_new_p0");
        expect_v(1, 1, 32'hA5A5_A5A5, "nobypass_new_p1");
        tick();

        // ---------------- dut2: NREGS = 24, three ports ------------------
        rst_s[2] = 1'b0;
        for (int i = 0; i <= 24; i++) begin
            if (i == 23 || i == 24)
                expect_v(2, -1, (i < 24) ? 32'd1 : 32'd0, "d24_sweep_busy");
            if (i < 24) tick();
        end
        set_wr(2, 1'b1, 5'd25, 32'h0000_0055);
        set_rd(2, 5'd25, 5'd25, 5'd25);
        for (int p = 0; p < 3; p++) expect_v(2, p, 32'h0, "oor_no_bypass");
        tick();
        set_wr(2, 1'b0, 5'd0, 32'h0);
        set_rd(2, 5'd25, 5'd23, 5'd0);
        for (int p = 0; p < 3; p++) expect_v(2, p, 32'h0, "oor_25_23_0");
        tick();
        set_wr(2, 1'b1, 5'd23, 32'h0000_0077);
        set_rd(2, 5'd0, 5'd23, 5'd25);
        expect_v(2, 0, 32'h0, "d24_x0");
        expect_v(2, 1, 32'h0000_0077, "d24_bypass_x23");
        expect_v(2, 2, 32'h0, "d24_oor");
        tick();
        set_wr(2, 1'b0, 5'd0, 32'h0);
        set_rd(2, 5'd23, 5'd23, 5'd23);
        for (int p = 0; p < 3; p++) expect_v(2, p, 32'h0000_0077, "d24_x23_readback");
        tick();

        tick();
        if (sb_q.size() != 0) begin
            tests_failed++;
            $display("[TB] FAIL scoreboard_drain: %0d left, required 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
